// File: rtl/trap_entry_seq.sv
// Trap entry sequencer: accepts a trap type and walks through the SPARC trap-entry
// steps (PSR update / TBR write, save PC into r17, save nPC into r18, redirect fetch).
// Taking a trap with ET=0 parks the block in a sticky error state until reset.
module trap_entry_seq #(
  parameter int unsigned NWINDOWS = 8,
  parameter int unsigned CWP_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trap_req,
  input  logic [7:0]       tt_in,
  input  logic             et_in,
  input  logic             s_in,
  input  logic [CWP_W-1:0] cwp_in,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      npc_in,
  input  logic [19:0]      tba_in,
  output logic             busy,
  output logic             psr_we,
  output logic [CWP_W-1:0] new_cwp,
  output logic             new_s,
  output logic             new_ps,
  output logic             new_et,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             tbr_we,
  output logic [31:0]      tbr_out,
  output logic             pc_we,
  output logic [31:0]      pc_out,
  output logic [31:0]      npc_out,
  output logic             trap_done,
  output logic             error_mode
);

  typedef enum logic [2:0] {
    StIdle,
    StWin,
    StSavePc,
    StSaveNpc,
    StJump,
    StError
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       tt_q, tt_d;
  logic [19:0]      tba_q, tba_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      npc_q, npc_d;
  logic             s_q, s_d;
  logic [CWP_W-1:0] new_cwp_q, new_cwp_d;
  logic [31:0]      pc_tgt_q, pc_tgt_d;
  logic [31:0]      npc_tgt_q, npc_tgt_d;
  logic             accept;
  logic [CWP_W-1:0] cwp_dec;
  logic [31:0]      tbr_val;

  assign tbr_val = {tba_q, tt_q, 4'b0000};

  // Next state, input latching on accept and fetch-target capture ahead of JUMP.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    cwp_dec   = (cwp_in == '0) ? CWP_W'(NWINDOWS - 1) : cwp_in - CWP_W'(1);
    unique case (state_q)
      StIdle: begin
        if (trap_req) begin
          accept  = 1'b1;
          state_d = et_in ? StWin : StError;
        end
      end
      StWin:     state_d = StSavePc;
      StSavePc:  state_d = StSaveNpc;
      StSaveNpc: state_d = StJump;
      StJump:    state_d = StIdle;
      StError:   state_d = StError;
      default:   state_d = StIdle;
    endcase
    tt_d      = accept ? tt_in  : tt_q;
    tba_d     = accept ? tba_in : tba_q;
    pc_d      = accept ? pc_in  : pc_q;
    npc_d     = accept ? npc_in : npc_q;
    s_d       = accept ? s_in   : s_q;
    // The window pointer only moves for a trap that actually enters a window.
    new_cwp_d = (accept && et_in) ? cwp_dec : new_cwp_q;
    pc_tgt_d  = (state_q == StSaveNpc) ? tbr_val : pc_tgt_q;
    npc_tgt_d = (state_q == StSaveNpc) ? tbr_val + 32'd4 : npc_tgt_q;
  end

  // State and latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      tt_q      <= '0;
      tba_q     <= '0;
      pc_q      <= '0;
      npc_q     <= '0;
      s_q       <= 1'b0;
      new_cwp_q <= '0;
      pc_tgt_q  <= '0;
      npc_tgt_q <= '0;
    end else begin
      state_q   <= state_d;
      tt_q      <= tt_d;
      tba_q     <= tba_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      s_q       <= s_d;
      new_cwp_q <= new_cwp_d;
      pc_tgt_q  <= pc_tgt_d;
      npc_tgt_q <= npc_tgt_d;
    end
  end

  // Moore outputs decoded from the registered state and latches.
  always_comb begin
    busy       = (state_q != StIdle);
    psr_we     = 1'b0;
    new_s      = 1'b0;
    new_et     = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = 5'd0;
    rf_wdata   = 32'd0;
    tbr_we     = 1'b0;
    pc_we      = 1'b0;
    trap_done  = 1'b0;
    error_mode = 1'b0;
    unique case (state_q)
      StWin: begin
        psr_we = 1'b1;
        tbr_we = 1'b1;
        new_s  = 1'b1;
      end
      StSavePc: begin
        rf_we    = 1'b1;
        rf_waddr = 5'd17;
        rf_wdata = pc_q;
      end
      StSaveNpc: begin
        rf_we    = 1'b1;
        rf_waddr = 5'd18;
        rf_wdata = npc_q;
      end
      StJump: begin
        pc_we     = 1'b1;
        trap_done = 1'b1;
      end
      StError: error_mode = 1'b1;
      default: ;
    endcase
  end

  assign new_cwp = new_cwp_q;
  assign new_ps  = s_q;
  assign tbr_out = tbr_val;
  assign pc_out  = pc_tgt_q;
  assign npc_out = npc_tgt_q;

endmodule

// File: tb/tb_trap_entry_seq.sv
// Directed bench for trap_entry_seq: walks the trap-entry sequence step by step and
// checks each output against hand-computed values.
module tb_trap_entry_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        trap_req;
  logic [7:0]  tt_in;
  logic        et_in;
  logic        s_in;
  logic [4:0]  cwp_in;
  logic [31:0] pc_in;
  logic [31:0] npc_in;
  logic [19:0] tba_in;
  logic        busy, psr_we, new_s, new_ps, new_et, rf_we, tbr_we, pc_we, trap_done, error_mode;
  logic [4:0]  new_cwp;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, tbr_out, pc_out, npc_out;

  int vectors    = 0;
  int miscompares = 0;
  int cnt_done, cnt_psr, cnt_tbr, cnt_pc, cnt_busy, cnt_err_wr;

  trap_entry_seq #(.NWINDOWS(8), .CWP_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .trap_req   (trap_req),
    .tt_in      (tt_in),
    .et_in      (et_in),
    .s_in       (s_in),
    .cwp_in     (cwp_in),
    .pc_in      (pc_in),
    .npc_in     (npc_in),
    .tba_in     (tba_in),
    .busy       (busy),
    .psr_we     (psr_we),
    .new_cwp    (new_cwp),
    .new_s      (new_s),
    .new_ps     (new_ps),
    .new_et     (new_et),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .tbr_we     (tbr_we),
    .tbr_out    (tbr_out),
    .pc_we      (pc_we),
    .pc_out     (pc_out),
    .npc_out    (npc_out),
    .trap_done  (trap_done),
    .error_mode (error_mode)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_trap(input logic [7:0] tt, input logic [19:0] tba, input logic [4:0] cwp,
                          input logic s, input logic et, input logic [31:0] pc,
                          input logic [31:0] npc);
    trap_req = 1'b1;
    tt_in    = tt;
    tba_in   = tba;
    cwp_in   = cwp;
    s_in     = s;
    et_in    = et;
    pc_in    = pc;
    npc_in   = npc;
  endtask

  // Sum of all write strobes; must stay zero in the error state.
  function automatic int strobes();
    return int'(psr_we) + int'(rf_we) + int'(tbr_we) + int'(pc_we);
  endfunction

  initial begin
    reset = 1'b1;
    set_trap(8'h00, 20'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    trap_req = 1'b1;
    tick();
    tick();
    // Reset state: everything zero even with trap_req high.
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'(strobes()), 32'd0);
    chk("rst_tbr", tbr_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_npc", npc_out, 32'h0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_cwp", 32'(new_cwp), 32'd0);
    chk("rst_err", 32'(error_mode), 32'd0);
    trap_req = 1'b0;
    reset = 1'b0;
    tick();

    // Test 1: basic trap entry.
    set_trap(8'h05, 20'h40000, 5'd3, 1'b0, 1'b1, 32'h100, 32'h104);
    tick();
    trap_req = 1'b0;
    chk("t1_win_psr_we", 32'(psr_we), 32'd1);
    chk("t1_win_tbr_we", 32'(tbr_we), 32'd1);
    chk("t1_win_cwp", 32'(new_cwp), 32'd2);
    chk("t1_win_s", 32'(new_s), 32'd1);
    chk("t1_win_ps", 32'(new_ps), 32'd0);
    chk("t1_win_et", 32'(new_et), 32'd0);
    chk("t1_win_tbr", tbr_out, 32'h40000050);
    chk("t1_win_busy", 32'(busy), 32'd1);
    chk("t1_win_rf_we", 32'(rf_we), 32'd0);
    tick();
    chk("t1_spc_we", 32'(rf_we), 32'd1);
    chk("t1_spc_addr", 32'(rf_waddr), 32'd17);
    chk("t1_spc_data", rf_wdata, 32'h100);
    chk("t1_spc_psr_we", 32'(psr_we), 32'd0);
    tick();
    chk("t1_snpc_we", 32'(rf_we), 32'd1);
    chk("t1_snpc_addr", 32'(rf_waddr), 32'd18);
    chk("t1_snpc_data", rf_wdata, 32'h104);
    tick();
    chk("t1_jmp_pc_we", 32'(pc_we), 32'd1);
    chk("t1_jmp_done", 32'(trap_done), 32'd1);
    chk("t1_jmp_pc", pc_out, 32'h40000050);
    chk("t1_jmp_npc", npc_out, 32'h40000054);
    chk("t1_jmp_rf_we", 32'(rf_we), 32'd0);
    tick();
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_done", 32'(trap_done), 32'd0);
    chk("t1_hold_pc", pc_out, 32'h40000050);
    chk("t1_hold_cwp", 32'(new_cwp), 32'd2);

    // Test 2: CWP wrap and all-ones TBR.
    set_trap(8'hFF, 20'hFFFFF, 5'd0, 1'b1, 1'b1, 32'hDEADBEE0, 32'hDEADBEE4);
    tick();
    trap_req = 1'b0;
    chk("t2_win_cwp", 32'(new_cwp), 32'd7);
    chk("t2_win_ps", 32'(new_ps), 32'd1);
    chk("t2_win_tbr", tbr_out, 32'hFFFFFFF0);
    tick();
    chk("t2_spc_data", rf_wdata, 32'hDEADBEE0);
    tick();
    chk("t2_snpc_data", rf_wdata, 32'hDEADBEE4);
    tick();
    chk("t2_jmp_pc", pc_out, 32'hFFFFFFF0);
    chk("t2_jmp_npc", npc_out, 32'hFFFFFFF4);
    tick();

    // Test 4: trap_req held, tt_in changed mid-sequence.
    set_trap(8'h05, 20'h12345, 5'd4, 1'b0, 1'b1, 32'h200, 32'h204);
    tick();
    chk("t4_win_tbr", tbr_out, 32'h12345050);
    tick();
    tt_in = 8'h2A;
    chk("t4_spc_tbr", tbr_out, 32'h12345050);
    tick();
    chk("t4_snpc_tbr", tbr_out, 32'h12345050);
    tick();
    chk("t4_jmp_pc", pc_out, 32'h12345050);
    tick();
    chk("t4_idle_busy", 32'(busy), 32'd0);
    tick();
    trap_req = 1'b0;
    chk("t4_reacc_psr_we", 32'(psr_we), 32'd1);
    chk("t4_reacc_tbr", tbr_out, 32'h123452A0);
    chk("t4_reacc_cwp", 32'(new_cwp), 32'd3);
    repeat (4) tick();
    chk("t4_end_busy", 32'(busy), 32'd0);

    // Test 3: trap with ET=0 enters sticky error mode.
    set_trap(8'h11, 20'h00001, 5'd2, 1'b0, 1'b0, 32'h300, 32'h304);
    tick();
    trap_req = 1'b0;
    cnt_err_wr = 0;
    cnt_busy = 0;
    for (int i = 0; i < 20; i++) begin
      cnt_err_wr += strobes() + int'(trap_done);
      cnt_busy += int'(error_mode & busy);
      if (i == 5) trap_req = 1'b1;
      tick();
    end
    trap_req = 1'b0;
    chk("t3_err_held", 32'(cnt_busy), 32'd20);
    chk("t3_err_no_writes", 32'(cnt_err_wr), 32'd0);
    chk("t3_err_still", 32'(error_mode), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t3_rst_err", 32'(error_mode), 32'd0);
    chk("t3_rst_busy", 32'(busy), 32'd0);

    // Test 5: reset during SAVE_PC.
    set_trap(8'h07, 20'h00002, 5'd5, 1'b0, 1'b1, 32'h400, 32'h404);
    tick();
    trap_req = 1'b0;
    tick();
    chk("t5_in_spc", 32'(rf_waddr), 32'd17);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_strobes", 32'(strobes()), 32'd0);
    tick();
    chk("t5_no_r18", 32'(rf_we), 32'd0);
    set_trap(8'h09, 20'h00003, 5'd1, 1'b1, 1'b1, 32'h500, 32'h504);
    tick();
    trap_req = 1'b0;
    chk("t5_new_win_cwp", 32'(new_cwp), 32'd0);
    chk("t5_new_tbr", tbr_out, 32'h00003090);
    repeat (4) tick();

    // Test 6: pulse widths over a single trap.
    set_trap(8'h03, 20'h00004, 5'd6, 1'b0, 1'b1, 32'h600, 32'h604);
    cnt_done = 0; cnt_psr = 0; cnt_tbr = 0; cnt_pc = 0; cnt_busy = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      trap_req = 1'b0;
      cnt_done += int'(trap_done);
      cnt_psr  += int'(psr_we);
      cnt_tbr  += int'(tbr_we);
      cnt_pc   += int'(pc_we);
      cnt_busy += int'(busy);
    end
    chk("t6_done_cycles", 32'(cnt_done), 32'd1);
    chk("t6_psr_cycles", 32'(cnt_psr), 32'd1);
    chk("t6_tbr_cycles", 32'(cnt_tbr), 32'd1);
    chk("t6_pc_cycles", 32'(cnt_pc), 32'd1);
    chk("t6_busy_cycles", 32'(cnt_busy), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
